// File: rtl/jk_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// jk_seq_ctrl_if -- command channel of the JK sequencing controller.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. The master keeps cmd_op/cmd_data/cmd_len stable while
// cmd_valid is high; the slave samples them only on the transfer edge and
// ignores every later change. cmd_ready is low whenever the slave is busy.
//
// Signals:
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave -> master  slave can accept a command
//   cmd_op     master -> slave  3-bit opcode
//   cmd_data   master -> slave  load value / toggle mask (WIDTH bits)
//   cmd_len    master -> slave  count length, 0 encodes 16
// ---------------------------------------------------------------------------
interface jk_seq_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/jk_seq_ctrl.sv
// ---------------------------------------------------------------------------
// jk_seq_ctrl -- drives the J/K inputs of WIDTH external JK flip-flops.
//
// Commands arrive on a valid/ready channel and either apply one J/K pattern
// for a single cycle (NOP, CLEAR, SET, LOAD, TOGGLE) or run a ripple-style
// binary counter on the cells for N cycles (COUNT_UP, optionally COUNT_DOWN),
// recomputing the toggle pattern every cycle from the fed-back cell outputs.
// The cells update on the falling edge of clk, so q_fb is settled before the
// next rising edge where it is used.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   cmd        command channel (jk_seq_ctrl_if.slave)
//   q_fb       Q outputs of the JK cells
//   jk         cell i gets J on jk[2i+1], K on jk[2i] (registered)
//   busy       command in progress (registered)
//   done       one-cycle pulse at command completion (registered)
//   state_dbg  current FSM state encoding (IDLE=0, APPLY=1, COUNT=2)
//
// Build option: define JK_SEQ_DOWN_COUNT_EN to enable opcode 110 COUNT_DOWN.
// Without it, opcode 110 behaves as NOP.
// ---------------------------------------------------------------------------
module jk_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  jk_seq_ctrl_if.slave       cmd,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [2*WIDTH-1:0] jk,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_SET   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_TOG   = 3'b100;
  localparam logic [2:0] OP_UP    = 3'b101;
  localparam logic [2:0] OP_DOWN  = 3'b110;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] jk_q, jk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         remaining_q, remaining_d;
  logic               down_q, down_d;

  logic               cmd_ready_w;
  logic               accept;
  logic [4:0]         len_n;

  // Interleave per-cell J and K bits into the jk bus.
  function automatic logic [2*WIDTH-1:0] jk_pack(input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = j[i];
      r[2*i]   = k[i];
    end
    return r;
  endfunction

  // Cells to toggle for one counter step: cell 0 always, cell i when every
  // lower cell is 1 (up) or 0 (down). Wrap-around falls out naturally.
  function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] q,
                                                   input logic down);
    logic [WIDTH-1:0] t;
    logic             carry;
    t     = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & (down ? ~q[i] : q[i]);
    end
    return t;
  endfunction

  // Ready is held low during reset so nothing can be accepted on the
  // release boundary.
  assign cmd_ready_w = (state_q == ST_IDLE) && rst_n;
  assign accept      = cmd.cmd_valid && cmd_ready_w;
  assign len_n       = (cmd.cmd_len == 4'd0) ? 5'd16 : {1'b0, cmd.cmd_len};

  always_comb begin
    state_d     = state_q;
    jk_d        = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    down_d      = down_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          busy_d  = 1'b1;
          state_d = ST_APPLY;
          unique case (cmd.cmd_op)
            OP_CLEAR: jk_d = jk_pack('0, '1);
            OP_SET:   jk_d = jk_pack('1, '0);
            OP_LOAD:  jk_d = jk_pack(cmd.cmd_data, ~cmd.cmd_data);
            OP_TOG:   jk_d = jk_pack(cmd.cmd_data, cmd.cmd_data);
            OP_UP: begin
              // The accept edge already drives the first of N patterns.
              state_d     = ST_COUNT;
              remaining_d = len_n;
              down_d      = 1'b0;
              jk_d        = jk_pack(toggle_mask(q_fb, 1'b0),
                                    toggle_mask(q_fb, 1'b0));
            end
`ifdef JK_SEQ_DOWN_COUNT_EN
            OP_DOWN: begin
              state_d     = ST_COUNT;
              remaining_d = len_n;
              down_d      = 1'b1;
              jk_d        = jk_pack(toggle_mask(q_fb, 1'b1),
                                    toggle_mask(q_fb, 1'b1));
            end
`else
            OP_DOWN:  jk_d = '0;
`endif
            // NOP and the reserved opcode run the APPLY flow with hold.
            default:  jk_d = '0;
          endcase
        end
      end

      ST_APPLY: begin
        jk_d    = '0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_COUNT: begin
        // remaining counts patterns still owed including the one already
        // on jk; reaching 1 means the last pattern has been applied.
        if (remaining_q <= 5'd1) begin
          jk_d        = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          remaining_d = 5'd0;
          state_d     = ST_IDLE;
        end else begin
          remaining_d = remaining_q - 5'd1;
          jk_d        = jk_pack(toggle_mask(q_fb, down_q),
                                toggle_mask(q_fb, down_q));
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      jk_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= 5'd0;
      down_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      jk_q        <= jk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      down_q      <= down_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_w;
  assign jk            = jk_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

  // Structural invariants of the FSM and its registered outputs.
  a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q != ST_IDLE));
  a_done_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> (state_q == ST_IDLE));
  a_count_has_work: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_COUNT) |-> (remaining_q != 5'd0));

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jk_seq_ctrl -- directed bench for jk_seq_ctrl with WIDTH=4. Four
// falling-edge JK cells are modelled here and their Q outputs feed q_fb.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_jk_seq_ctrl;

  localparam int WIDTH = 4;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_SET   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_TOG   = 3'b100;
  localparam logic [2:0] OP_UP    = 3'b101;
  localparam logic [2:0] OP_DOWN  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jk_seq_ctrl_if #(.WIDTH(WIDTH)) cmd_if ();

  logic [2*WIDTH-1:0] jk;
  logic               busy;
  logic               done;
  logic [1:0]         state_dbg;
  logic [WIDTH-1:0]   q_cells = '0;

  jk_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd_if.slave),
    .q_fb      (q_cells),
    .jk        (jk),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // External JK cells, updating on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      case ({jk[2*i+1], jk[2*i]})
        2'b01:   q_cells[i] <= 1'b0;
        2'b10:   q_cells[i] <= 1'b1;
        2'b11:   q_cells[i] <= ~q_cells[i];
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, then presents the command for one edge.
  task automatic send(input logic [2:0] op, input logic [3:0] data,
                      input logic [3:0] len);
    int waited;
    waited = 0;
    while (!cmd_if.cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_eq("ready_before_send", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_len   = len;
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    // Scramble the inputs: they must not matter after acceptance.
    cmd_if.cmd_op    = 3'($urandom_range(0, 7));
    cmd_if.cmd_data  = 4'($urandom_range(0, 15));
    cmd_if.cmd_len   = 4'($urandom_range(0, 15));
  endtask

  int accepts;
  int dones;
  int busy_cyc;

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_len   = '0;

    // ---- reset held for two edges ----
    tick();
    tick();
    check_eq("rst_jk", 32'(jk), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // ---- CLEAR then LOAD 1010 ----
    send(OP_CLEAR, 4'h0, 4'h0);
    check_eq("clear_jk", 32'(jk), 32'h55);
    check_eq("clear_busy", 32'(busy), 32'd1);
    check_eq("clear_ready", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    check_eq("clear_done", 32'(done), 32'd1);
    check_eq("clear_q", 32'(q_cells), 32'h0);
    send(OP_LOAD, 4'b1010, 4'h0);
    check_eq("load_jk", 32'(jk), 32'b1001_1001);
    check_eq("load_done_low", 32'(done), 32'd0);
    check_eq("load_state", 32'(state_dbg), 32'd1);
    tick();
    check_eq("load_done", 32'(done), 32'd1);
    check_eq("load_jk_idle", 32'(jk), 32'h0);
    check_eq("load_q", 32'(q_cells), 32'b1010);

    // ---- SET, then reserved opcode holds ----
    send(OP_SET, 4'h0, 4'h0);
    check_eq("set_jk", 32'(jk), 32'hAA);
    tick();
    check_eq("set_q", 32'(q_cells), 32'hF);
    send(OP_RSVD, 4'hF, 4'h0);
    check_eq("rsvd_jk", 32'(jk), 32'h0);
    tick();
    check_eq("rsvd_done", 32'(done), 32'd1);
    check_eq("rsvd_q", 32'(q_cells), 32'hF);

    // ---- COUNT_UP len=3 from 1110 ----
    send(OP_LOAD, 4'b1110, 4'h0);
    tick();
    check_eq("pre_up_q", 32'(q_cells), 32'b1110);
    dones = 0;
    send(OP_UP, 4'h0, 4'd3);
    busy_cyc = int'(busy);
    check_eq("up_jk0", 32'(jk), 32'h03);
    check_eq("up_state", 32'(state_dbg), 32'd2);
    tick();
    busy_cyc += int'(busy);
    dones    += int'(done);
    check_eq("up_q1", 32'(q_cells), 32'b1111);
    check_eq("up_jk1", 32'(jk), 32'hFF);
    tick();
    busy_cyc += int'(busy);
    dones    += int'(done);
    check_eq("up_q2", 32'(q_cells), 32'b0000);
    check_eq("up_jk2", 32'(jk), 32'h03);
    tick();
    busy_cyc += int'(busy);
    dones    += int'(done);
    check_eq("up_q3", 32'(q_cells), 32'b0001);
    check_eq("up_jk_end", 32'(jk), 32'h0);
    check_eq("up_busy_cycles", 32'(busy_cyc), 32'd3);
    check_eq("up_done_count", 32'(dones), 32'd1);

    // ---- TOGGLE 0101 with cmd_valid held high ----
    cmd_if.cmd_op    = OP_TOG;
    cmd_if.cmd_data  = 4'b0101;
    cmd_if.cmd_len   = 4'h0;
    cmd_if.cmd_valid = 1'b1;
    accepts = 0;
    dones   = 0;
    for (int c = 0; c < 4; c++) begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) accepts++;
      tick();
      dones += int'(done);
      if (c == 1) check_eq("tog_q_first", 32'(q_cells), 32'b0100);
    end
    cmd_if.cmd_valid = 1'b0;
    check_eq("tog_accepts", 32'(accepts), 32'd2);
    check_eq("tog_dones", 32'(dones), 32'd2);
    check_eq("tog_q_second", 32'(q_cells), 32'b0001);

    // ---- COUNT_UP len=0 (16) aborted by reset after 5 edges ----
    send(OP_CLEAR, 4'h0, 4'h0);
    tick();
    dones = 0;
    send(OP_UP, 4'h0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      dones += int'(done);
    end
    rst_n = 1'b0;
    tick();
    dones += int'(done);
    check_eq("abort_q", 32'(q_cells), 32'b0101);
    check_eq("abort_jk", 32'(jk), 32'h0);
    check_eq("abort_state", 32'(state_dbg), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(cmd_if.cmd_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    dones += int'(done);
    check_eq("abort_no_done", 32'(dones), 32'd0);
    check_eq("abort_q_hold", 32'(q_cells), 32'b0101);
    check_eq("abort_ready_back", 32'(cmd_if.cmd_ready), 32'd1);

    // ---- COUNT_DOWN len=2 from 0000 ----
    send(OP_CLEAR, 4'h0, 4'h0);
    tick();
    check_eq("pre_down_q", 32'(q_cells), 32'h0);
    send(OP_DOWN, 4'h0, 4'd2);
`ifdef JK_SEQ_DOWN_COUNT_EN
    check_eq("down_jk0", 32'(jk), 32'hFF);
    tick();
    check_eq("down_q1", 32'(q_cells), 32'b1111);
    check_eq("down_jk1", 32'(jk), 32'h03);
    check_eq("down_busy1", 32'(busy), 32'd1);
    tick();
    check_eq("down_q2", 32'(q_cells), 32'b1110);
    check_eq("down_done", 32'(done), 32'd1);
`else
    check_eq("down_nop_jk", 32'(jk), 32'h0);
    tick();
    check_eq("down_nop_done", 32'(done), 32'd1);
    check_eq("down_nop_q", 32'(q_cells), 32'h0);
`endif
    tick();
    check_eq("final_done_low", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, legal range 1..16, setting the number of controlled JK cells.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all block state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: the command is present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 3 bits: the opcode.
REQ-007 The block SHALL have port cmd_data, input, WIDTH bits: the load value or toggle mask.
REQ-008 The block SHALL have port cmd_len, input, 4 bits: the count length; 0 means 16.
REQ-009 The block SHALL have port q_fb, input, WIDTH bits: the Q outputs fed back from the JK cells, which update on the falling edge of clk.
REQ-010 The block SHALL have port jk, output, 2*WIDTH bits, where cell i receives J on jk[2i+1] and K on jk[2i].
REQ-011 The block SHALL have port busy, output, 1 bit: a command is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse at command completion.

Function
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal (state==IDLE).
REQ-014 The FSM SHALL have the states IDLE, APPLY and COUNT, with registered jk, busy and done outputs.
REQ-015 In IDLE, jk SHALL be all 00 (hold), busy SHALL be 0 and done SHALL be 0 except for the post-completion pulse.
REQ-016 On accepting a single-cycle op, the block SHALL drive the pattern on jk, set busy=1 and go to APPLY; on the next edge it SHALL drive jk=00, pulse done=1, clear busy and return to IDLE.
REQ-017 Opcode 000 NOP and opcode 111 (reserved) SHALL use the APPLY flow with a pattern of all 00.
REQ-018 Opcode 001 CLEAR SHALL drive every cell with J=0, K=1.
REQ-019 Opcode 010 SET SHALL drive every cell with J=1, K=0.
REQ-020 Opcode 011 LOAD SHALL drive J=cmd_data[i], K=~cmd_data[i].
REQ-021 Opcode 100 TOGGLE SHALL drive J=K=cmd_data[i].
REQ-022 Opcode 101 COUNT_UP SHALL latch N=cmd_len (0 maps to 16) into a 5-bit remaining counter, enter COUNT and drive J=K=1 for cell i when q_fb[i-1:0] is all ones (cell 0 is always toggled).
REQ-023 In COUNT, the block SHALL recompute the pattern from the current q_fb on each rising edge.
REQ-024 COUNT SHALL produce exactly N patterns: the accept edge plus N-1 further edges; on edge N the block SHALL drive jk=00, pulse done and return to IDLE.
REQ-025 The count SHALL wrap modulo 2^WIDTH with no flag (all-ones +1 -> 0).
REQ-026 Command inputs SHALL be sampled only at acceptance; later changes to them SHALL be ignored.
REQ-027 While busy, cmd_valid SHALL be ignored and cmd_ready SHALL be 0; back-to-back commands SHALL be possible with one IDLE cycle between them (the done cycle).
REQ-028 The latency from accept to done SHALL be 1 cycle for single-cycle ops and N cycles for counts.

Reset
REQ-029 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, jk=0, busy=0, done=0 and remaining=0; cmd_ready SHALL be 0 while rst_n=0 and 1 on the first edge after release.
REQ-030 A reset asserted during APPLY or COUNT SHALL abort the command with no done pulse; the cells hold their last value thereafter.

Configuration
REQ-031 The macro JK_SEQ_DOWN_COUNT_EN, when defined, SHALL make opcode 110 COUNT_DOWN behave like COUNT_UP but toggle cell i when q_fb[i-1:0] is all zeros, wrapping 0 -> all ones.
REQ-032 When JK_SEQ_DOWN_COUNT_EN is undefined, opcode 110 SHALL behave as NOP: one cycle of jk=00 followed by done.

Verification (bench: WIDTH=4, jk driving four falling-edge JK cells whose q feeds q_fb)
REQ-033 Hold rst_n low for 2 edges -> jk=0, busy=0, done=0, cmd_ready=0; first edge after release -> cmd_ready=1.
REQ-034 CLEAR then LOAD cmd_data=4'b1010 -> jk=8'b10_01_10_01 for one cycle, done pulses one edge later, q_fb=1010.
REQ-035 From q=1110, COUNT_UP cmd_len=3 -> q steps 1111, 0000, 0001; busy high 3 cycles; one done pulse.
REQ-036 TOGGLE cmd_data=4'b0101 from q=0001 -> q=0100; cmd_valid held high through busy -> exactly one accept per IDLE cycle.
REQ-037 COUNT_UP cmd_len=0 from q=0000 with rst_n pulled low after 5 edges -> q=0101, no done, jk=0, state IDLE.
REQ-038 COUNT_DOWN cmd_len=2 from q=0000 -> q steps 1111, 1110 with JK_SEQ_DOWN_COUNT_EN defined, and q stays 0000 with done after 1 cycle when it is undefined.
